// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: operand/address widths and the compare-flag bundle
// used by the register file, ALU and branch unit.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
        logic overflow;
    } cmp_flags_t;

endpackage

// File: rtl/flag_reg.sv
// Status flags: shift-carry plus the four compare flags, each group with its own
// load enable. Outputs are purely registered so nothing loops back into the ALU.
module flag_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sc_wr_en,
    input  logic       sc_in,
    input  logic       cmp_wr_en,
    input  cmp_flags_t cmp_in,
    output logic       sc_out,
    output cmp_flags_t cmp_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_out  <= 1'b0;
            cmp_out <= '0;
        end else begin
            if (sc_wr_en) begin
                sc_out <= sc_in;
            end
            // all four compare flags move together; *_in is never looked at otherwise
            if (cmp_wr_en) begin
                cmp_out <= cmp_in;
            end
        end
    end

endmodule

// File: rtl/reg_file_flags.sv
// Architectural register file feeding the ALU operands, with optional write-to-read
// bypass, a non-bypassed debug port, and the status-flag register.
module reg_file_flags
    import cpu_pkg::*;
#(
    parameter int W      = DATA_W,
    parameter int A      = ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [A-1:0] rd_addr_a,
    input  logic [A-1:0] rd_addr_b,
    output logic [W-1:0] rd_data_a,
    output logic [W-1:0] rd_data_b,
    input  logic         sc_wr_en,
    input  logic         sc_in,
    output logic         sc_out,
    input  logic         cmp_wr_en,
    input  logic         zero_in,
    input  logic         sign_in,
    input  logic         carry_in,
    input  logic         overflow_in,
    output logic         zero_f,
    output logic         sign_f,
    output logic         carry_f,
    output logic         overflow_f,
    input  logic [A-1:0] dbg_addr,
    output logic [W-1:0] dbg_data
);

    localparam int NREGS = 1 << A;

    logic [W-1:0] regs [NREGS];
    logic         wr_live;
    cmp_flags_t   cmp_in;
    cmp_flags_t   cmp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // a write squashed by reset must not leak onto the operand ports
    assign wr_live = BYPASS && wr_en && !reset;

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_live && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_live && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

    assign dbg_data = regs[dbg_addr];

    assign cmp_in = '{zero: zero_in, sign: sign_in, carry: carry_in, overflow: overflow_in};

    flag_reg u_flag_reg (
        .clk       (clk),
        .reset     (reset),
        .sc_wr_en  (sc_wr_en),
        .sc_in     (sc_in),
        .cmp_wr_en (cmp_wr_en),
        .cmp_in    (cmp_in),
        .sc_out    (sc_out),
        .cmp_out   (cmp_q)
    );

    assign zero_f     = cmp_q.zero;
    assign sign_f     = cmp_q.sign;
    assign carry_f    = cmp_q.carry;
    assign overflow_f = cmp_q.overflow;

endmodule

// File: tb/tb_reg_file_flags.sv
// Directed bench for reg_file_flags: a bypassing and a non-bypassing instance
// share one stimulus so both read behaviours are checked side by side.
module tb_reg_file_flags;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic       sc_wr_en;
    logic       sc_in;
    logic       cmp_wr_en;
    logic       zero_in, sign_in, carry_in, overflow_in;
    logic [2:0] dbg_addr;

    logic [7:0] rd_data_a, rd_data_b, dbg_data;
    logic       sc_out, zero_f, sign_f, carry_f, overflow_f;
    logic [7:0] nb_rd_data_a, nb_rd_data_b, nb_dbg_data;
    logic       nb_sc_out, nb_zero_f, nb_sign_f, nb_carry_f, nb_overflow_f;

    int checks   = 0;
    int failures = 0;

    reg_file_flags #(.W(8), .A(3), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .sc_wr_en(sc_wr_en), .sc_in(sc_in), .sc_out(sc_out),
        .cmp_wr_en(cmp_wr_en), .zero_in(zero_in), .sign_in(sign_in), .carry_in(carry_in),
        .overflow_in(overflow_in), .zero_f(zero_f), .sign_f(sign_f), .carry_f(carry_f),
        .overflow_f(overflow_f), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    reg_file_flags #(.W(8), .A(3), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
        .sc_wr_en(sc_wr_en), .sc_in(sc_in), .sc_out(nb_sc_out),
        .cmp_wr_en(cmp_wr_en), .zero_in(zero_in), .sign_in(sign_in), .carry_in(carry_in),
        .overflow_in(overflow_in), .zero_f(nb_zero_f), .sign_f(nb_sign_f), .carry_f(nb_carry_f),
        .overflow_f(nb_overflow_f), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wr_en = 1'b0; sc_wr_en = 1'b0; cmp_wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; sc_in = 1'b0;
        zero_in = 1'b0; sign_in = 1'b0; carry_in = 1'b0; overflow_in = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
        sc_wr_en = 1'b1; sc_in = 1'b1;
        cmp_wr_en = 1'b1; zero_in = 1'b1; sign_in = 1'b1; carry_in = 1'b1; overflow_in = 1'b1;
        rd_addr_a = 3'd3; rd_addr_b = 3'd0; dbg_addr = 3'd3;
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_data_a !== 8'h00) begin
            failures++; $display("FAIL reset_rd_a actual=%h expected=00", rd_data_a);
        end
        checks++;
        if (dbg_data !== 8'h00) begin
            failures++; $display("FAIL reset_dbg actual=%h expected=00", dbg_data);
        end
        checks++;
        if ({sc_out, zero_f, sign_f, carry_f, overflow_f} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b expected=00000", {sc_out, zero_f, sign_f, carry_f, overflow_f});
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5C;
        step();
        idle_inputs();
        rd_addr_a = 3'd2; rd_addr_b = 3'd2; dbg_addr = 3'd2;
        #1;
        checks++;
        if (rd_data_a !== 8'h5C || rd_data_b !== 8'h5C) begin
            failures++; $display("FAIL write_read_ab actual=%h/%h expected=5c/5c", rd_data_a, rd_data_b);
        end
        checks++;
        if (dbg_data !== 8'h5C) begin
            failures++; $display("FAIL write_read_dbg actual=%h expected=5c", dbg_data);
        end
        checks++;
        if (nb_rd_data_a !== 8'h5C || nb_rd_data_b !== 8'h5C) begin
            failures++; $display("FAIL write_read_nb actual=%h/%h expected=5c/5c", nb_rd_data_a, nb_rd_data_b);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h7E;
        rd_addr_a = 3'd5; rd_addr_b = 3'd2; dbg_addr = 3'd5;
        #1;
        checks++;
        if (rd_data_a !== 8'h7E) begin
            failures++; $display("FAIL bypass_a actual=%h expected=7e", rd_data_a);
        end
        checks++;
        if (rd_data_b !== 8'h5C) begin
            failures++; $display("FAIL bypass_b_nomatch actual=%h expected=5c", rd_data_b);
        end
        checks++;
        if (dbg_data !== 8'h00) begin
            failures++; $display("FAIL bypass_dbg actual=%h expected=00", dbg_data);
        end
        checks++;
        if (nb_rd_data_a !== 8'h00) begin
            failures++; $display("FAIL nobypass_old actual=%h expected=00", nb_rd_data_a);
        end
        rd_addr_b = 3'd5;
        #1;
        checks++;
        if (rd_data_b !== 8'h7E) begin
            failures++; $display("FAIL bypass_both actual=%h expected=7e", rd_data_b);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (nb_rd_data_a !== 8'h7E || rd_data_a !== 8'h7E) begin
            failures++; $display("FAIL bypass_after_edge actual=%h/%h expected=7e/7e", rd_data_a, nb_rd_data_a);
        end
    endtask

    task automatic test_cmp_flags();
        idle_inputs();
        cmp_wr_en = 1'b1; zero_in = 1'b1; sign_in = 1'b0; carry_in = 1'b1; overflow_in = 1'b0;
        #1;
        checks++;
        if ({zero_f, sign_f, carry_f, overflow_f} !== 4'b0000) begin
            failures++; $display("FAIL cmp_pre_edge actual=%b expected=0000", {zero_f, sign_f, carry_f, overflow_f});
        end
        step();
        checks++;
        if ({zero_f, sign_f, carry_f, overflow_f} !== 4'b1010) begin
            failures++; $display("FAIL cmp_load actual=%b expected=1010", {zero_f, sign_f, carry_f, overflow_f});
        end
        idle_inputs();
        step();
        checks++;
        if ({zero_f, sign_f, carry_f, overflow_f} !== 4'b1010) begin
            failures++; $display("FAIL cmp_hold_zero actual=%b expected=1010", {zero_f, sign_f, carry_f, overflow_f});
        end
        zero_in = 1'bx; sign_in = 1'bx; carry_in = 1'bx; overflow_in = 1'bx;
        step();
        checks++;
        if ({zero_f, sign_f, carry_f, overflow_f} !== 4'b1010) begin
            failures++; $display("FAIL cmp_hold_x actual=%b expected=1010", {zero_f, sign_f, carry_f, overflow_f});
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        sc_wr_en = 1'b1; sc_in = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h01;
        cmp_wr_en = 1'b1; zero_in = 1'b0; sign_in = 1'b1; carry_in = 1'b0; overflow_in = 1'b1;
        dbg_addr = 3'd7;
        #1;
        checks++;
        if (sc_out !== 1'b0) begin
            failures++; $display("FAIL sc_pre_edge actual=%b expected=0", sc_out);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (sc_out !== 1'b1) begin
            failures++; $display("FAIL sc_load actual=%b expected=1", sc_out);
        end
        checks++;
        if (dbg_data !== 8'h01) begin
            failures++; $display("FAIL simul_r7 actual=%h expected=01", dbg_data);
        end
        checks++;
        if ({zero_f, sign_f, carry_f, overflow_f} !== 4'b0101) begin
            failures++; $display("FAIL simul_flags actual=%b expected=0101", {zero_f, sign_f, carry_f, overflow_f});
        end
        step();
        checks++;
        if (sc_out !== 1'b1) begin
            failures++; $display("FAIL sc_hold actual=%b expected=1", sc_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] val;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'h10 + 8'(i);
            step();
        end
        idle_inputs();
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'h16) begin
            failures++; $display("FAIL fill_r6 actual=%h expected=16", dbg_data);
        end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hEE;
        sc_wr_en = 1'b1; sc_in = 1'b1; cmp_wr_en = 1'b1; zero_in = 1'b1;
        rd_addr_a = 3'd3;
        #1;
        checks++;
        if (rd_data_a !== 8'h13) begin
            failures++; $display("FAIL reset_no_bypass actual=%h expected=13", rd_data_a);
        end
        step();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i); dbg_addr = 3'(i);
            #1;
            val = rd_data_a | rd_data_b | dbg_data | nb_rd_data_a | nb_dbg_data;
            checks++;
            if (val !== 8'h00) begin
                failures++; $display("FAIL reset_mid_r%0d actual=%h expected=00", i, val);
            end
        end
        checks++;
        if ({sc_out, zero_f, sign_f, carry_f, overflow_f} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_flags actual=%b expected=00000", {sc_out, zero_f, sign_f, carry_f, overflow_f});
        end
    endtask

    initial begin
        idle_inputs();
        rd_addr_a = '0; rd_addr_b = '0; dbg_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_cmp_flags();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
